// File: rtl/seq_1011010_gen_if.sv
// Word handshake between a payload producer and the serial frame transmitter.
// A word moves on a rising edge where data_valid && data_ready; the producer holds data_in steady while data_valid is high.
interface seq_1011010_gen_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input  data_ready);
  modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

// File: rtl/seq_1011010_gen.sv
// Serial frame transmitter: sync word, payload MSB first, then GAP idle bits.
// All line outputs are registered so a downstream detector sees a clean stream.
module seq_1011010_gen #(
  parameter int                SYNC_W       = 7,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 7'b1011010,
  parameter int                DATA_W       = 8,
  parameter int                GAP          = 2,
  parameter logic              IDLE_BIT     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_1011010_gen_if.slave        dif,
  output logic                    sout,
  output logic                    busy,
  output logic                    sync_done,
  output logic                    frame_done,
  output logic [1:0]              state_dbg
);

  localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_N = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              sout_n, sync_done_n, frame_done_n;
  logic [SYNC_W-1:0] sync_sh;

  assign dif.data_ready = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sout       <= IDLE_BIT;
      sync_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      sout       <= sout_n;
      sync_done  <= sync_done_n;
      frame_done <= frame_done_n;
    end
  end

  // cnt always holds the index of the bit currently on sout within its phase.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    sout_n       = sout;
    sync_done_n  = 1'b0;
    frame_done_n = 1'b0;
    sync_sh      = '0;
    case (state)
      S_IDLE: begin
        sout_n = IDLE_BIT;
        if (dif.data_valid) begin
          shreg_n     = dif.data_in;
          sout_n      = SYNC_PATTERN[SYNC_W-1];
          cnt_n       = SYNC_LAST;
          sync_done_n = (SYNC_W == 1);
          state_n     = S_SYNC;
        end
      end
      S_SYNC: begin
        if (cnt != '0) begin
          cnt_n       = cnt - ONE;
          sync_sh     = SYNC_PATTERN >> cnt_n;
          sout_n      = sync_sh[0];
          sync_done_n = (cnt_n == '0);
        end else begin
          sout_n       = shreg[DATA_W-1];
          shreg_n      = shreg << 1;
          cnt_n        = DATA_LAST;
          frame_done_n = (DATA_W == 1);
          state_n      = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt != '0) begin
          cnt_n        = cnt - ONE;
          sout_n       = shreg[DATA_W-1];
          shreg_n      = shreg << 1;
          frame_done_n = (cnt_n == '0);
        end else begin
          sout_n = IDLE_BIT;
          if (GAP > 0) begin
            cnt_n   = GAP_LAST;
            state_n = S_GAP;
          end else begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        sout_n = IDLE_BIT;
        if (cnt != '0) cnt_n = cnt - ONE;
        else           state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_1011010_gen.sv
// Directed bench for seq_1011010_gen with a behavioural 1011010 detector on the line.
module tb_seq_1011010_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       sout, busy, sync_done, frame_done;
  logic [1:0] state_dbg;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  seq_1011010_gen_if #(.DATA_W(8)) dif ();

  seq_1011010_gen dut (
    .clk        (clk),
    .reset      (reset),
    .dif        (dif),
    .sout       (sout),
    .busy       (busy),
    .sync_done  (sync_done),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Overlapping 1011010 detector, registered: pulses the cycle after the last matching bit.
  logic [6:0] hist;
  logic       det;
  always @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      det  <= 1'b0;
    end else begin
      hist <= {hist[5:0], sout};
      det  <= ({hist[5:0], sout} == 7'b1011010);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!dif.data_ready && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (!dif.data_ready) begin
      failures++;
      $display("FAIL %s_timeout data_ready=%0b required=1", name, dif.data_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.data_valid = 1'b0;
    dif.data_in = '0;
    repeat (3) step();
    checks++;
    if ({sout, dif.data_ready, busy, sync_done, frame_done} !== 5'b01000) begin
      failures++;
      $display("FAIL reset_outputs got={sout,rdy,busy,sd,fd}=%b required=01000",
               {sout, dif.data_ready, busy, sync_done, frame_done});
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d required=0", state_dbg);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({dif.data_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL post_reset_idle got={rdy,busy}=%b required=10", {dif.data_ready, busy});
    end
  endtask

  task automatic test_frame_a5();
    logic [16:0] exp_bits;
    logic [3:0]  obs, exp_v;
    exp_bits = {7'b1011010, 8'hA5, 2'b00};
    dif.data_in = 8'hA5;
    dif.data_valid = 1'b1;
    step();
    dif.data_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      obs   = {sout, sync_done, frame_done, busy};
      exp_v = {exp_bits[16-i], (i == 6), (i == 14), 1'b1};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL frame_a5_cycle%0d got={sout,sd,fd,busy}=%b required=%b", i + 1, obs, exp_v);
      end
      step();
    end
    checks++;
    if ({dif.data_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL frame_a5_ready18 got={rdy,busy}=%b required=10", {dif.data_ready, busy});
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, n_acc, low_run, max_low;
    logic [7:0] pay1, pay2;
    t0 = 0; t1 = 0; n_acc = 0; low_run = 0; max_low = 0;
    pay1 = 8'h55; pay2 = 8'h55;
    dif.data_in = 8'h00;
    dif.data_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (n_acc >= 1 && c - t0 >= 8 && c - t0 <= 15) pay1 = {pay1[6:0], sout};
      if (n_acc >= 2 && c - t1 >= 8 && c - t1 <= 15) pay2 = {pay2[6:0], sout};
      if (!busy) low_run++;
      else low_run = 0;
      if (low_run > max_low) max_low = low_run;
      if (n_acc == 1 && c == t0 + 1) dif.data_in = 8'hFF;
      if (dif.data_ready) begin
        if (n_acc == 0) t0 = c;
        else if (n_acc == 1) t1 = c;
        n_acc++;
      end
      step();
    end
    dif.data_valid = 1'b0;
    checks++;
    if (n_acc < 2 || t1 - t0 != 18) begin
      failures++;
      $display("FAIL b2b_period accepts=%0d spacing=%0d required=18", n_acc, t1 - t0);
    end
    checks++;
    if (pay1 !== 8'h00) begin
      failures++;
      $display("FAIL b2b_payload1 got=%h required=00", pay1);
    end
    checks++;
    if (pay2 !== 8'hFF) begin
      failures++;
      $display("FAIL b2b_payload2 got=%h required=ff", pay2);
    end
    checks++;
    if (max_low > 1) begin
      failures++;
      $display("FAIL b2b_busy_low got=%0d required<=1", max_low);
    end
    wait_idle("b2b");
  endtask

  task automatic test_ignore_while_busy();
    logic [7:0] pay;
    int ready_seen;
    pay = 8'h00;
    ready_seen = 0;
    dif.data_in = 8'h3C;
    dif.data_valid = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      if (i >= 7 && i <= 14) pay = {pay[6:0], sout};
      if (dif.data_ready) ready_seen++;
      dif.data_valid = (i % 2 == 0) && (i != 16);
      dif.data_in = ~dif.data_in;
      step();
    end
    dif.data_valid = 1'b0;
    checks++;
    if (ready_seen != 0) begin
      failures++;
      $display("FAIL busy_ready_low got=%0d ready cycles required=0", ready_seen);
    end
    checks++;
    if (pay !== 8'h3C) begin
      failures++;
      $display("FAIL busy_payload got=%h required=3c", pay);
    end
    checks++;
    if (dif.data_ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_end_ready got=%b required=1", dif.data_ready);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_no_accept got=%b required=0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [16:0] exp_bits;
    int fd_seen, busy_seen;
    fd_seen = 0;
    busy_seen = 0;
    dif.data_in = 8'hA5;
    dif.data_valid = 1'b1;
    step();
    dif.data_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (sout !== 1'b1) begin
      failures++;
      $display("FAIL abort_third_bit got=%b required=1", sout);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({sout, busy, dif.data_ready} !== 3'b001) begin
      failures++;
      $display("FAIL abort_reset got={sout,busy,rdy}=%b required=001", {sout, busy, dif.data_ready});
    end
    for (int i = 0; i < 20; i++) begin
      if (frame_done) fd_seen++;
      if (busy) busy_seen++;
      step();
    end
    checks++;
    if (fd_seen != 0 || busy_seen != 0) begin
      failures++;
      $display("FAIL abort_no_resume got fd=%0d busy=%0d required 0 0", fd_seen, busy_seen);
    end
    // reset and valid together: reset wins; the following edge then accepts
    dif.data_in = 8'h81;
    dif.data_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_valid got busy=%b required=0", busy);
    end
    step();
    dif.data_valid = 1'b0;
    exp_bits = {7'b1011010, 8'h81, 2'b00};
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (sout !== exp_bits[16-i]) begin
        failures++;
        $display("FAIL fresh_frame_bit%0d got=%b required=%b", i + 1, sout, exp_bits[16-i]);
      end
      step();
    end
    wait_idle("fresh");
  endtask

  task automatic test_loopback();
    logic [7:0] payload;
    int np, p0, p1;
    for (int k = 0; k < 2; k++) begin
      payload = (k == 0) ? 8'h00 : 8'h5A;
      np = 0; p0 = -1; p1 = -1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      dif.data_in = payload;
      dif.data_valid = 1'b1;
      step();
      dif.data_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (det) begin
          if (np == 0) p0 = i;
          else if (np == 1) p1 = i;
          np++;
        end
        step();
      end
      checks++;
      if (np != k + 1) begin
        failures++;
        $display("FAIL loop_%h_count got=%0d required=%0d", payload, np, k + 1);
      end
      checks++;
      if (p0 != 7) begin
        failures++;
        $display("FAIL loop_%h_first got=%0d required=7", payload, p0);
      end
      if (k == 1) begin
        checks++;
        if (p1 != 15) begin
          failures++;
          $display("FAIL loop_%h_second got=%0d required=15", payload, p1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
